// File: rtl/rif_arbiter.sv
// Shares one single-cycle-strobe register-interface target between NUM_REQ requesters.
// One transaction in flight: accept -> RIF strobe -> held response to the owner only.
module rif_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RR_ARB     = 1
) (
    input  logic                                aclk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    input  logic [NUM_REQ-1:0]                  rsp_ready,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic [ADDR_WIDTH-1:0]               rif_waddr,
    output logic                                rif_wr_req,
    output logic [(DATA_WIDTH/8)-1:0]           rif_wstrb,
    output logic [DATA_WIDTH-1:0]               rif_wdata,
    input  logic                                rif_wvalid,
    output logic [ADDR_WIDTH-1:0]               rif_raddr,
    output logic                                rif_rd_req,
    input  logic [DATA_WIDTH-1:0]               rif_rdata,
    input  logic                                rif_rvalid
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1) begin : g_bad_num_req
        $fatal(1, "rif_arbiter: NUM_REQ must be >= 1");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $fatal(1, "rif_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        rr_next_s;
    logic [PTR_W-1:0]        owner_r;
    logic                    write_r;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    grant_found_s;
    int                      base_s;
    logic [NUM_REQ-1:0]      gnt_onehot_s;
    logic [NUM_REQ-1:0]      owner_onehot_s;
    logic [NUM_REQ-1:0]      req_ready_s;
    logic                    accept_s;
    logic                    rsp_hs_s;
    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [STRB_WIDTH-1:0]   sel_wstrb_s;
    logic [NUM_REQ-1:0]      rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic [ADDR_WIDTH-1:0]   rif_waddr_r;
    logic                    rif_wr_req_r;
    logic [STRB_WIDTH-1:0]   rif_wstrb_r;
    logic [DATA_WIDTH-1:0]   rif_wdata_r;
    logic [ADDR_WIDTH-1:0]   rif_raddr_r;
    logic                    rif_rd_req_r;

    // Grant scan: first valid at or above the start index, then the wrapped part below it.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {PTR_W{1'b0}};
        base_s        = (RR_ARB != 0) ? int'(rr_ptr_r) : 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_idx_s   = (!grant_found_s && req_valid[k] && (k >= base_s)) ? PTR_W'(k) : grant_idx_s;
            grant_found_s = grant_found_s | (req_valid[k] && (k >= base_s));
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_idx_s   = (!grant_found_s && req_valid[k] && (k < base_s)) ? PTR_W'(k) : grant_idx_s;
            grant_found_s = grant_found_s | (req_valid[k] && (k < base_s));
        end
    end

    // Winner payload mux and one-hot decodes of the grant and the current owner.
    always_comb begin
        gnt_onehot_s   = {NUM_REQ{1'b0}};
        owner_onehot_s = {NUM_REQ{1'b0}};
        sel_write_s    = 1'b0;
        sel_addr_s     = {ADDR_WIDTH{1'b0}};
        sel_wdata_s    = {DATA_WIDTH{1'b0}};
        sel_wstrb_s    = {STRB_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_onehot_s[k]   = grant_found_s & (grant_idx_s == PTR_W'(k));
            owner_onehot_s[k] = (owner_r == PTR_W'(k));
            sel_write_s = gnt_onehot_s[k] ? req_write[k] : sel_write_s;
            sel_addr_s  = gnt_onehot_s[k] ? req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_wdata_s = gnt_onehot_s[k] ? req_wdata[k*DATA_WIDTH +: DATA_WIDTH] : sel_wdata_s;
            sel_wstrb_s = gnt_onehot_s[k] ? req_wstrb[k*STRB_WIDTH +: STRB_WIDTH] : sel_wstrb_s;
        end
    end

    assign rsp_hs_s  = |(rsp_valid_r & rsp_ready);
    assign rr_next_s = (owner_r == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (owner_r + PTR_W'(1'b1));

    // Next-state and accept decode; no grant is offered while reset is high.
    always_comb begin
        next_state_s = state_r;
        req_ready_s  = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s && !reset) begin
                    req_ready_s  = gnt_onehot_s;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    assign accept_s = |req_ready_s;

    // State register.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Transaction latch, RIF strobe generation and response capture.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rr_ptr_r     <= {PTR_W{1'b0}};
            owner_r      <= {PTR_W{1'b0}};
            write_r      <= 1'b0;
            rsp_valid_r  <= {NUM_REQ{1'b0}};
            rsp_rdata_r  <= {DATA_WIDTH{1'b0}};
            rsp_err_r    <= 1'b0;
            rif_waddr_r  <= {ADDR_WIDTH{1'b0}};
            rif_wr_req_r <= 1'b0;
            rif_wstrb_r  <= {STRB_WIDTH{1'b0}};
            rif_wdata_r  <= {DATA_WIDTH{1'b0}};
            rif_raddr_r  <= {ADDR_WIDTH{1'b0}};
            rif_rd_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r      <= grant_idx_s;
                        write_r      <= sel_write_s;
                        rif_wr_req_r <= sel_write_s;
                        rif_rd_req_r <= ~sel_write_s;
                        rif_waddr_r  <= sel_write_s ? sel_addr_s  : {ADDR_WIDTH{1'b0}};
                        rif_wdata_r  <= sel_write_s ? sel_wdata_s : {DATA_WIDTH{1'b0}};
                        rif_wstrb_r  <= sel_write_s ? sel_wstrb_s : {STRB_WIDTH{1'b0}};
                        rif_raddr_r  <= sel_write_s ? {ADDR_WIDTH{1'b0}} : sel_addr_s;
                    end
                end
                ST_ISSUE: begin
                    rif_wr_req_r <= 1'b0;
                    rif_rd_req_r <= 1'b0;
                    rif_waddr_r  <= {ADDR_WIDTH{1'b0}};
                    rif_wdata_r  <= {DATA_WIDTH{1'b0}};
                    rif_wstrb_r  <= {STRB_WIDTH{1'b0}};
                    rif_raddr_r  <= {ADDR_WIDTH{1'b0}};
                    rsp_valid_r  <= owner_onehot_s;
                    rsp_err_r    <= write_r ? ~rif_wvalid : ~rif_rvalid;
                    rsp_rdata_r  <= write_r ? {DATA_WIDTH{1'b0}} : rif_rdata;
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= {NUM_REQ{1'b0}};
                        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                        rsp_err_r   <= 1'b0;
                        rr_ptr_r    <= rr_next_s;
                    end
                end
                default: begin
                    rif_wr_req_r <= 1'b0;
                    rif_rd_req_r <= 1'b0;
                    rsp_valid_r  <= {NUM_REQ{1'b0}};
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign rif_waddr  = rif_waddr_r;
    assign rif_wr_req = rif_wr_req_r;
    assign rif_wstrb  = rif_wstrb_r;
    assign rif_wdata  = rif_wdata_r;
    assign rif_raddr  = rif_raddr_r;
    assign rif_rd_req = rif_rd_req_r;

endmodule
